multiplier_seq: RTL
===================

Name: multiplier_seq

Overview:
- Sequential RV32M multiply unit: executes MUL, MULH, MULHSU and MULHU.
- Sits beside the divider in the execute stage and uses the same start/stall/done handshake, so execute-stage control treats both units identically.
- Radix-2 shift-add on operand magnitudes, one bit per cycle, then a one-cycle sign fix-up.
- Result held stable until the next accepted operation.

Parameters:
- None. Operand width is fixed at 32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mul_start  input  1  request; sampled only in IDLE.
- mul_op  input  3 (mult_funct3_t)  MUL=000, MULH=001, MULHSU=010, MULHU=011; encodings with bit[2]=1 are not multiplies.
- multiplicand  input  32  RS1 operand.
- multiplier  input  32  RS2 operand.
- product  output  32  result: low word for MUL, high word for the MULH variants.
- mul_stall  output  1  pipeline stall request.
- mul_done  output  1  one-cycle pulse; product is valid.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; product=0; mul_done=0; internal accumulator, counter and operand registers cleared.
- A reset mid-operation aborts the operation: no mul_done, product=0.
- States: IDLE, COMPUTE, FIXUP, DONE.
- IDLE:
  - Accept when mul_start=1 and mul_op[2]=0.
  - On accept: latch the op, sign flag and operand magnitudes; clear the 64-bit accumulator; counter=0; go to COMPUTE.
  - mul_start with mul_op[2]=1 is ignored: stay in IDLE, mul_stall=0.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
  - Magnitude = two's-complement negate if the operand is treated as signed and its MSB=1.
  - 0x80000000 maps to magnitude 0x80000000, which is exact as unsigned 32-bit.
  - Sign flag = XOR of the effective operand signs.
- COMPUTE: exactly 32 cycles.
  - Each cycle: if multiplier_reg[0]=1, add the shifted multiplicand into the accumulator.
  - Then shift: multiplicand left by 1, multiplier right by 1.
  - counter increments 0..31; at counter=31 go to FIXUP.
  - No early termination; zero operands still take the full latency.
- FIXUP: 1 cycle.
  - If sign flag=1, accumulator = two's-complement negate (64-bit).
  - Load product: MUL gets acc[31:0]; all others get acc[63:32].
  - Go to DONE.
- DONE: mul_done=1 for exactly this one cycle, mul_stall=0; return to IDLE next cycle.
- Latency: accept on edge 0 → mul_done high in the cycle following edge 33 (34 cycles after the accept cycle).
- mul_stall:
  - Combinational 1 in IDLE when a valid mul_start is present.
  - 1 throughout COMPUTE and FIXUP.
  - 0 in DONE and in idle IDLE.
  - Net effect: the requesting instruction stalls from its first cycle until mul_done.
- mul_start outside IDLE, including during DONE, is ignored. Operand or op changes after accept do not affect the result.
- Back-to-back: a start held high is re-accepted in the IDLE cycle after DONE, starting a new operation.
- product holds its value from FIXUP until the next FIXUP or reset. It does not change on accept.
- All arithmetic is modulo 2^64 internally; overflow is impossible for a 32x32 magnitude product.

Test Plan:
- MUL 0x00000007 × 0xFFFFFFFD (−3) → product=0xFFFFFFEB. mul_done pulses exactly once, 34 cycles after the accept cycle; mul_stall high from the start cycle through FIXUP.
- MULH 0x80000000 × 0x80000000 → product=0x40000000. MUL on the same operands → 0x00000000.
- MULHSU 0xFFFFFFFF (−1) × 0xFFFFFFFF (unsigned) → product=0xFFFFFFFF. MULHU on the same operands → 0xFFFFFFFE.
- Start accepted; operands and mul_op changed and mul_start re-pulsed during COMPUTE → original result delivered, single mul_done. mul_op=100 with mul_start → no accept, mul_stall=0.
- rst asserted asynchronously at cycle 10 of COMPUTE → immediate IDLE, product=0, no mul_done. A new MUL 3×5 afterwards → 0x0000000F after 34 cycles.
- mul_start held high for two ops (MUL 0×0x12345678, then MULHU 0x10000×0x10000) → 0x00000000 then 0x00000001. The second accept happens in the IDLE cycle after the first DONE, and product holds 0 until the second FIXUP.

Source files
------------

// File: rtl/multiplier_seq_if.sv
// Start/stall/done handshake bundle shared by the execute-stage multiply unit.
// master = execute-stage control, slave = multiplier.
interface multiplier_seq_if;
    logic        mul_start;
    logic [2:0]  mul_op;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] product;
    logic        mul_stall;
    logic        mul_done;

    modport master (
        output mul_start,
        output mul_op,
        output multiplicand,
        output multiplier,
        input  product,
        input  mul_stall,
        input  mul_done
    );

    modport slave (
        input  mul_start,
        input  mul_op,
        input  multiplicand,
        input  multiplier,
        output product,
        output mul_stall,
        output mul_done
    );
endinterface

// File: rtl/multiplier_seq.sv
// Sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU): radix-2 shift-add on operand
// magnitudes, one bit per cycle, followed by a single sign fix-up cycle.
module multiplier_seq (
    input logic             clk,
    input logic             rst,
    multiplier_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCompute, StFixup, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] product_q, product_d;

    logic        accept;
    logic        rs1_signed;
    logic        rs2_signed;
    logic        rs1_neg;
    logic        rs2_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc_fix;
    logic        stall;
    logic        done;

    // Operand decode uses the live inputs; only meaningful in the accept cycle.
    always_comb begin
        accept     = bus.mul_start & ~bus.mul_op[2];
        rs1_signed = (bus.mul_op[1:0] != 2'b11);
        rs2_signed = ~bus.mul_op[1];
        rs1_neg    = rs1_signed & bus.multiplicand[31];
        rs2_neg    = rs2_signed & bus.multiplier[31];
        mag_a      = rs1_neg ? (32'd0 - bus.multiplicand) : bus.multiplicand;
        mag_b      = rs2_neg ? (32'd0 - bus.multiplier) : bus.multiplier;
        acc_fix    = neg_q ? (64'd0 - acc_q) : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        stall     = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall    = 1'b1;
                    op_d     = bus.mul_op[1:0];
                    neg_d    = rs1_neg ^ rs2_neg;
                    mcand_d  = {32'd0, mag_a};
                    mplier_d = mag_b;
                    acc_d    = 64'd0;
                    cnt_d    = 5'd0;
                    state_d  = StCompute;
                end
            end
            StCompute: begin
                stall = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                stall     = 1'b1;
                acc_d     = acc_fix;
                product_d = (op_q == 2'b00) ? acc_fix[31:0] : acc_fix[63:32];
                state_d   = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= 2'b00;
            neg_q     <= 1'b0;
            mcand_q   <= 64'd0;
            mplier_q  <= 32'd0;
            acc_q     <= 64'd0;
            cnt_q     <= 5'd0;
            product_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.product   = product_q;
    assign bus.mul_stall = stall;
    assign bus.mul_done  = done;
endmodule
